// File: rtl/avr_io_irqctl_if.sv
// ---------------------------------------------------------------------------
// avr_io_irqctl_if
// Bundles the I/O-register bus and the interrupt handshake of the AVR-style
// interrupt controller.
//   io_re/io_we  : address-qualified read/write strobes from the core
//   io_a         : register index (0 PEND, 1 MASK, 2 EDGE, 3 VEC)
//   io_din       : write data from the core
//   io_dout      : read data onto the core's wired-OR bus (0 when not read)
//   irq_in       : request lines, synchronous to clk
//   iack/iack_vec: one-cycle acknowledge strobe and the vector it acknowledges
//   iflag/ivect  : registered interrupt request and winning vector to the core
// master = core/system side, slave = the controller.
// ---------------------------------------------------------------------------
interface avr_io_irqctl_if #(
    parameter int NIRQ = 4
);
    logic            io_re;
    logic            io_we;
    logic [1:0]      io_a;
    logic [7:0]      io_din;
    logic [7:0]      io_dout;
    logic [NIRQ-1:0] irq_in;
    logic            iack;
    logic [1:0]      iack_vec;
    logic            iflag;
    logic [1:0]      ivect;

    modport master (
        output io_re, io_we, io_a, io_din, irq_in, iack, iack_vec,
        input  io_dout, iflag, ivect
    );

    modport slave (
        input  io_re, io_we, io_a, io_din, irq_in, iack, iack_vec,
        output io_dout, iflag, ivect
    );
endinterface

// File: rtl/avr_io_irqctl.sv
// ---------------------------------------------------------------------------
// avr_io_irqctl
// Four-source interrupt controller with a small I/O register file.
//   clk : system clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : avr_io_irqctl_if.slave (register bus + interrupt handshake)
// Registers: 0 PEND (read, W1C on edge-mode bits), 1 MASK, 2 EDGE
// (1 = rising-edge, 0 = level), 3 VEC = {iflag, 5'b0, ivect} (read only).
// Lower index wins priority. iflag/ivect are registered from pend & mask.
// ---------------------------------------------------------------------------
module avr_io_irqctl #(
    parameter int NIRQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    avr_io_irqctl_if.slave      bus
);

    logic [NIRQ-1:0] irq_q_reg;
    logic [NIRQ-1:0] pend_reg;
    logic [NIRQ-1:0] pend_next;
    logic [NIRQ-1:0] mask_reg;
    logic [NIRQ-1:0] edge_mode_reg;
    logic            iflag_reg;
    logic [1:0]      ivect_reg;
    logic [1:0]      ivect_next;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] ack_hit;
    logic [NIRQ-1:0] to_edge;
    logic [NIRQ-1:0] active;
    logic [7:0]      rdata;

    logic wr_pend;
    logic wr_mask;
    logic wr_edge;

    assign wr_pend = bus.io_we && (bus.io_a == 2'd0);
    assign wr_mask = bus.io_we && (bus.io_a == 2'd1);
    assign wr_edge = bus.io_we && (bus.io_a == 2'd2);

    always_comb begin
        rise    = bus.irq_in & ~irq_q_reg;
        w1c     = wr_pend ? bus.io_din[NIRQ-1:0] : '0;
        // Bits switching from level to edge mode in this write.
        to_edge = wr_edge ? (bus.io_din[NIRQ-1:0] & ~edge_mode_reg) : '0;
        ack_hit = '0;
        if (bus.iack) begin
            ack_hit[bus.iack_vec] = 1'b1;
        end
    end

    // Per-source pending logic. Edge mode: a fresh rising edge always wins
    // over a same-cycle clear (W1C or ack), so no edge is ever lost.
    // Level mode: pend simply mirrors the line, except on the cycle the bit
    // is switched to edge mode, where stale level state is discarded.
    generate
        for (genvar gi = 0; gi < NIRQ; gi++) begin : g_pend
            assign pend_next[gi] = edge_mode_reg[gi]
                ? (rise[gi] | (pend_reg[gi] & ~(w1c[gi] | ack_hit[gi])))
                : (to_edge[gi] ? rise[gi] : bus.irq_in[gi]);
        end
    endgenerate

    assign active = pend_reg & mask_reg;

    // Lowest set index wins; scanning downward leaves it as the final write.
    always_comb begin
        ivect_next = 2'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                ivect_next = 2'(i);
            end
        end
    end

    // irq_q keeps sampling through reset so a line already high when reset
    // releases is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        irq_q_reg <= bus.irq_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg      <= '0;
            mask_reg      <= '0;
            edge_mode_reg <= '1;
            iflag_reg     <= 1'b0;
            ivect_reg     <= 2'd0;
        end else begin
            pend_reg  <= pend_next;
            iflag_reg <= |active;
            ivect_reg <= ivect_next;
            if (wr_mask) begin
                mask_reg <= bus.io_din[NIRQ-1:0];
            end
            if (wr_edge) begin
                edge_mode_reg <= bus.io_din[NIRQ-1:0];
            end
        end
    end

    // Read data must be zero when not selected: the core ORs all devices.
    always_comb begin
        rdata = 8'h00;
        if (bus.io_re) begin
            case (bus.io_a)
                2'd0:    rdata = {{(8-NIRQ){1'b0}}, pend_reg};
                2'd1:    rdata = {{(8-NIRQ){1'b0}}, mask_reg};
                2'd2:    rdata = {{(8-NIRQ){1'b0}}, edge_mode_reg};
                default: rdata = {iflag_reg, 5'b0, ivect_reg};
            endcase
        end
    end

    assign bus.io_dout = rdata;
    assign bus.iflag   = iflag_reg;
    assign bus.ivect   = ivect_reg;

endmodule

// File: doc/avr_io_irqctl.md
AVR_IO_IRQCTL -- requirements
Module: avr_io_irqctl

Interface
REQ-001 The block SHALL have parameter NIRQ, default 4, meaning the number of interrupt sources; the only supported value is 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port io_re, input, 1 bit: I/O read strobe, already qualified by the block's address select.
REQ-005 The block SHALL have port io_we, input, 1 bit: I/O write strobe, already qualified by the block's address select.
REQ-006 The block SHALL have port io_a, input, 2 bits: register index.
REQ-007 The block SHALL have port io_din, input, 8 bits: write data from the core.
REQ-008 The block SHALL have port io_dout, output, 8 bits: read data to the core's wired-OR I/O bus.
REQ-009 The block SHALL have port irq_in, input, 4 bits: request lines, synchronous to clk.
REQ-010 The block SHALL have port iack, input, 1 bit: one-cycle interrupt-acknowledge strobe from the core.
REQ-011 The block SHALL have port iack_vec, input, 2 bits: the vector being acknowledged, valid when iack=1.
REQ-012 The block SHALL have port iflag, output, 1 bit: interrupt request to the core, registered.
REQ-013 The block SHALL have port ivect, output, 2 bits: vector of the highest-priority request, registered.

Function
REQ-014 Register 0 (PEND) SHALL read {4'b0, pend[3:0]}; writing 1 to bit i SHALL clear pend[i] when i is edge-mode; writing 0 has no effect.
REQ-015 Register 1 (MASK) SHALL read {4'b0, mask[3:0]}; a write SHALL load mask from io_din[3:0].
REQ-016 Register 2 (EDGE) SHALL read {4'b0, edge[3:0]}, where 1 means rising-edge and 0 means level; a write SHALL load edge from io_din[3:0].
REQ-017 Register 3 (VEC) SHALL read {iflag, 5'b0, ivect}; writes to it SHALL be ignored.
REQ-018 io_dout SHALL be combinational from the current register state when io_re=1, and SHALL be 8'h00 when io_re=0.
REQ-019 The block SHALL keep a registered copy of irq_in, irq_q, which samples irq_in every cycle including during reset.
REQ-020 For each edge-mode bit i, the block SHALL set pend[i] at the clock edge that samples irq_in[i]=1 with irq_q[i]=0.
REQ-021 For each level-mode bit i, the block SHALL load pend[i] with irq_in[i] every cycle, ignoring W1C and ack.
REQ-022 When iack=1 and bit iack_vec is edge-mode, the block SHALL clear pend[iack_vec] at that clock edge; acking a non-pending vector has no effect.
REQ-023 For an edge-mode bit, a new edge in the same cycle as an ack or W1C of that bit SHALL leave pend set.
REQ-024 A write to EDGE that changes bit i from 0 to 1 SHALL clear pend[i] at that edge, unless REQ-023 applies.
REQ-025 The block SHALL register iflag from |(pend & mask) and ivect from the lowest set index of (pend & mask), or 0 if none.
REQ-026 Latency: irq_in rising before edge k SHALL set pend after edge k and iflag after edge k+1; mask changes SHALL reach iflag one cycle after the write.
REQ-027 After an ack at edge k, iflag and ivect SHALL reflect the remaining requests after edge k+1.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set pend=0, mask=0, edge=4'hF, iflag=0 and ivect=0; irq_q SHALL still follow REQ-019.
REQ-029 rst SHALL take priority over io_we, iack and irq_in.
REQ-030 A line already high when rst deasserts SHALL NOT produce an edge-mode pend.

Verification
REQ-031 Write MASK=4'h4, then pulse irq_in[2] -> PEND reads 8'h04 one cycle later; iflag=1 and ivect=2 one cycle after that; VEC reads 8'h82.
REQ-032 Set MASK=4'hF and raise irq_in[3] and irq_in[1] together -> ivect=1; iack with iack_vec=1 -> next cycle ivect=3 and iflag=1; iack with iack_vec=3 -> iflag=0.
REQ-033 Write EDGE=4'hE and MASK=4'h1, hold irq_in[0]=1 -> iflag stays 1 across iack with iack_vec=0; drop irq_in[0] -> iflag=0 two cycles later.
REQ-034 Edge-mode bit 2 pending, with a W1C of 8'h04 and a new irq_in[2] edge in the same cycle -> PEND still reads 8'h04.
REQ-035 Hold irq_in=4'hF through rst, deassert rst with MASK=4'hF -> PEND=0 and iflag=0; drop the lines then raise irq_in[0] -> iflag=1 and ivect=0 after 2 cycles.
REQ-036 Assert rst mid-operation with iflag=1 -> next cycle iflag=0, EDGE reads 8'h0F, MASK reads 8'h00, and io_dout=0 whenever io_re=0.
